// File: rtl/data_memory_mmio.sv
// Data-side memory for the single-cycle MIPS core: word RAM plus an MMIO window
// holding LEDs, synchronised switches and a compare timer with a level interrupt.
module data_memory_mmio #(
  parameter int DEPTH    = 64,
  parameter int SW_WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                MemWrite,
  input  logic [31:0]         Address,
  input  logic [31:0]         WriteData,
  output logic [31:0]         ReadData,
  input  logic [SW_WIDTH-1:0] Switches,
  output logic [SW_WIDTH-1:0] Leds,
  output logic                TimerIrq
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

  localparam logic [31:0] ADDR_LED     = 32'hFFFF_0000;
  localparam logic [31:0] ADDR_SWITCH  = 32'hFFFF_0004;
  localparam logic [31:0] ADDR_COUNT   = 32'hFFFF_0008;
  localparam logic [31:0] ADDR_COMPARE = 32'hFFFF_000C;
  localparam logic [31:0] ADDR_CTRL    = 32'hFFFF_0010;

  logic [31:0]         mem [DEPTH];
  logic [SW_WIDTH-1:0] sw_meta;
  logic [SW_WIDTH-1:0] sw_sync;
  logic [31:0]         count;
  logic [31:0]         compare;
  logic                enable;
  logic                irq_en;
  logic                match;
  logic                addr_err;

  logic aligned;
  logic is_ram;
  logic is_led;
  logic is_switch;
  logic is_count;
  logic is_compare;
  logic is_ctrl;
  logic mapped;
  logic wr_ram;
  logic wr_led;
  logic wr_count;
  logic wr_compare;
  logic wr_ctrl;
  logic bad_wr;
  logic match_hit;

  always_comb begin
    aligned    = (Address[1:0] == 2'b00);
    is_ram     = (Address[31:16] == 16'h0000) && (Address < RAM_BYTES);
    is_led     = (Address == ADDR_LED);
    is_switch  = (Address == ADDR_SWITCH);
    is_count   = (Address == ADDR_COUNT);
    is_compare = (Address == ADDR_COMPARE);
    is_ctrl    = (Address == ADDR_CTRL);
    mapped     = is_ram || is_led || is_switch || is_count || is_compare || is_ctrl;
    wr_ram     = MemWrite && aligned && is_ram;
    wr_led     = MemWrite && is_led;
    wr_count   = MemWrite && is_count;
    wr_compare = MemWrite && is_compare;
    wr_ctrl    = MemWrite && is_ctrl;
    // Only stores can flag an error; the datapath drives Address on every cycle.
    bad_wr     = MemWrite && (!aligned || !mapped);
    match_hit  = !wr_count && enable && (count == compare);
  end

  always_comb begin
    ReadData = 32'h0;
    if (aligned) begin
      if (is_ram)          ReadData = mem[Address[AW+1:2]];
      else if (is_led)     ReadData = 32'(Leds);
      else if (is_switch)  ReadData = 32'(sw_sync);
      else if (is_count)   ReadData = count;
      else if (is_compare) ReadData = compare;
      else if (is_ctrl)    ReadData = {22'h0, addr_err, match, 6'h0, irq_en, enable};
    end
  end

  // RAM has no reset; a store coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && wr_ram) mem[Address[AW+1:2]] <= WriteData;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      Leds     <= '0;
      sw_meta  <= '0;
      sw_sync  <= '0;
      count    <= 32'h0;
      compare  <= 32'hFFFF_FFFF;
      enable   <= 1'b0;
      irq_en   <= 1'b0;
      match    <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      sw_meta <= Switches;
      sw_sync <= sw_meta;
      if (wr_led)     Leds    <= WriteData[SW_WIDTH-1:0];
      if (wr_compare) compare <= WriteData;
      if (wr_count)       count <= WriteData;
      else if (match_hit) count <= 32'h0;
      else if (enable)    count <= count + 32'h1;
      if (wr_ctrl) begin
        enable <= WriteData[0];
        irq_en <= WriteData[1];
      end
      // Setting a sticky flag takes precedence over a same-edge W1C.
      if (match_hit)                     match <= 1'b1;
      else if (wr_ctrl && WriteData[8])  match <= 1'b0;
      if (bad_wr)                        addr_err <= 1'b1;
      else if (wr_ctrl && WriteData[9])  addr_err <= 1'b0;
    end
  end

  assign TimerIrq = match && irq_en;

endmodule

// File: tb/tb_data_memory_mmio.sv
// Directed bench for data_memory_mmio: RAM, MMIO decode, errors, timer, switches, reset.
module tb_data_memory_mmio;

  localparam int SW_WIDTH = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic                MemWrite;
  logic [31:0]         Address;
  logic [31:0]         WriteData;
  logic [31:0]         ReadData;
  logic [SW_WIDTH-1:0] Switches;
  logic [SW_WIDTH-1:0] Leds;
  logic                TimerIrq;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] rd;

  data_memory_mmio #(.DEPTH(64), .SW_WIDTH(SW_WIDTH)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .Address(Address),
    .WriteData(WriteData), .ReadData(ReadData), .Switches(Switches),
    .Leds(Leds), .TimerIrq(TimerIrq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Inputs change at the falling edge; outputs are sampled 1ns after the rising edge.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    Address = addr; WriteData = data; MemWrite = 1'b1;
    @(posedge clk); #1;
    MemWrite = 1'b0;
  endtask

  task automatic rd_word(input logic [31:0] addr, output logic [31:0] data);
    MemWrite = 1'b0; Address = addr;
    #1 data = ReadData;
  endtask

  task automatic idle(input int n);
    MemWrite = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; MemWrite = 1'b0; Address = 32'h0; WriteData = 32'h0; Switches = '0;
    idle(2);
    @(negedge clk); reset = 1'b0;
    idle(1);

    // Reset state
    check("rst_leds", 32'(Leds), 32'h0);
    check("rst_irq", 32'(TimerIrq), 32'h0);
    rd_word(32'hFFFF_0008, rd); check("rst_count", rd, 32'h0);
    rd_word(32'hFFFF_000C, rd); check("rst_compare", rd, 32'hFFFF_FFFF);
    rd_word(32'hFFFF_0010, rd); check("rst_ctrl", rd, 32'h0);

    // RAM store/load, including same-cycle read of the word being written
    wr(32'h0000_0014, 32'hCAFE_F00D);
    wr(32'h0000_0010, 32'h1111_1111);
    @(negedge clk);
    Address = 32'h0000_0010; WriteData = 32'hDEAD_BEEF; MemWrite = 1'b1;
    #1 check("ram_same_cycle_old", ReadData, 32'h1111_1111);
    @(posedge clk); #1; MemWrite = 1'b0;
    rd_word(32'h0000_0010, rd); check("ram_rd_0x10", rd, 32'hDEAD_BEEF);
    rd_word(32'h0000_0014, rd); check("ram_rd_0x14", rd, 32'hCAFE_F00D);
    rd_word(32'h0000_00FC, rd); wr(32'h0000_00FC, 32'h0BAD_F00D);
    rd_word(32'h0000_00FC, rd); check("ram_last_word", rd, 32'h0BAD_F00D);

    // Misaligned and unmapped accesses
    wr(32'hFFFF_0002, 32'h0000_1234);
    check("misal_leds", 32'(Leds), 32'h0);
    rd_word(32'hFFFF_0010, rd); check("misal_err", rd, 32'h200);
    rd_word(32'hFFFF_0002, rd); check("misal_rd", rd, 32'h0);
    wr(32'h0000_0012, 32'h5555_5555);
    rd_word(32'h0000_0010, rd); check("misal_ram_kept", rd, 32'hDEAD_BEEF);
    wr(32'hFFFF_0010, 32'h0000_0200);
    rd_word(32'hFFFF_0010, rd); check("err_w1c", rd, 32'h0);
    rd_word(32'h0001_0000, rd); check("unmapped_rd", rd, 32'h0);
    idle(1);
    rd_word(32'hFFFF_0010, rd); check("rd_no_err", rd, 32'h0);
    wr(32'h0000_0100, 32'h1);
    rd_word(32'hFFFF_0010, rd); check("past_ram_err", rd, 32'h200);
    wr(32'hFFFF_0010, 32'h0000_0200);
    wr(32'hFFFF_0004, 32'hFFFF_FFFF);
    rd_word(32'hFFFF_0010, rd); check("sw_wr_no_err", rd, 32'h0);

    // Timer: COMPARE=3, enable -> match 4 edges after enable write
    wr(32'hFFFF_000C, 32'h3);
    wr(32'hFFFF_0010, 32'h3);
    for (int i = 1; i <= 4; i++) begin
      idle(1);
      check($sformatf("irq_edge%0d", i), 32'(TimerIrq), (i == 4) ? 32'h1 : 32'h0);
    end
    rd_word(32'hFFFF_0008, rd); check("count_at_match", rd, 32'h0);
    wr(32'hFFFF_0010, 32'h103);
    check("irq_cleared", 32'(TimerIrq), 32'h0);
    rd_word(32'hFFFF_0010, rd); check("ctrl_cleared", rd, 32'h3);
    rd_word(32'hFFFF_0008, rd); check("count_after_clr", rd, 32'h1);
    for (int i = 1; i <= 3; i++) begin
      idle(1);
      check($sformatf("refire_edge%0d", i), 32'(TimerIrq), (i == 3) ? 32'h1 : 32'h0);
    end
    // Next match lands on the same edge as a W1C of match: the set wins
    idle(3);
    rd_word(32'hFFFF_0008, rd); check("count_pre_match", rd, 32'h3);
    wr(32'hFFFF_0010, 32'h103);
    rd_word(32'hFFFF_0010, rd); check("set_beats_clr", rd, 32'h103);
    check("irq_set_beats_clr", 32'(TimerIrq), 32'h1);
    rd_word(32'hFFFF_0008, rd); check("count_wrapped_match", rd, 32'h0);
    // COUNT write beats increment; then 0xFFFF_FFFF wraps to 0
    wr(32'hFFFF_0008, 32'hFFFF_FFFF);
    rd_word(32'hFFFF_0008, rd); check("count_load", rd, 32'hFFFF_FFFF);
    idle(1);
    rd_word(32'hFFFF_0008, rd); check("count_wrap", rd, 32'h0);
    wr(32'hFFFF_0010, 32'h101);
    check("irq_en_off", 32'(TimerIrq), 32'h0);

    // Switch synchroniser and LED register
    @(negedge clk); Switches = 16'hA5A5;
    idle(1);
    rd_word(32'hFFFF_0004, rd); check("sw_1edge", rd, 32'h0);
    idle(1);
    rd_word(32'hFFFF_0004, rd); check("sw_2edge", rd, 32'h0000_A5A5);
    wr(32'hFFFF_0000, 32'hFFFF_00FF);
    check("leds_out", 32'(Leds), 32'h0000_00FF);
    rd_word(32'hFFFF_0000, rd); check("leds_rd", rd, 32'h0000_00FF);

    // Mid-operation reset with concurrent stores
    wr(32'hFFFF_0010, 32'h3);
    wr(32'hFFFF_000C, 32'h10);
    wr(32'h0000_0020, 32'h55AA_55AA);
    @(negedge clk);
    reset = 1'b1; MemWrite = 1'b1; Address = 32'hFFFF_0000; WriteData = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    @(negedge clk);
    Address = 32'h0000_0020; WriteData = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    reset = 1'b0; MemWrite = 1'b0;
    check("mid_rst_leds", 32'(Leds), 32'h0);
    check("mid_rst_irq", 32'(TimerIrq), 32'h0);
    rd_word(32'hFFFF_0008, rd); check("mid_rst_count", rd, 32'h0);
    rd_word(32'hFFFF_000C, rd); check("mid_rst_compare", rd, 32'hFFFF_FFFF);
    rd_word(32'hFFFF_0010, rd); check("mid_rst_ctrl", rd, 32'h0);
    rd_word(32'hFFFF_0004, rd); check("mid_rst_sw", rd, 32'h0);
    rd_word(32'h0000_0020, rd); check("mid_rst_ram_kept", rd, 32'h55AA_55AA);
    rd_word(32'h0000_0010, rd); check("mid_rst_ram_old", rd, 32'hDEAD_BEEF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
